// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: the machine word and the pipeline skid-register states.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline skid register (main + skid) with flush, sticky halt and
// a saturating downstream-stall counter. All outputs are registered.
//
//   state | meaning
//   EMPTY | nothing held, out_valid=0, in_ready=1 unless halted
//   ONE   | head in main, skid free, in_ready=1
//   FULL  | head in main, next entry parked in skid, in_ready=0
module pipe_skid_reg
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = $bits(word_t),
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_halt,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_halt,
    input  logic             out_ready,
    input  logic             flush,
    output logic             halted,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    skid_state_t      state;
    logic [WIDTH-1:0] skid_data;
    logic             skid_halt;
    logic             accept;
    logic             pop;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_halt  <= 1'b0;
            skid_data <= '0;
            skid_halt <= 1'b0;
            halted    <= 1'b0;
            occupancy <= 2'd0;
            stall_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end

            if (flush) begin
                state     <= EMPTY;
                out_valid <= 1'b0;
                occupancy <= 2'd0;
                in_ready  <= !halted;
            end else if (pop && out_halt) begin
                // A retiring halt stops the stage: anything behind it, and any
                // entry offered this cycle, is dropped and the block closes.
                halted    <= 1'b1;
                state     <= EMPTY;
                out_valid <= 1'b0;
                occupancy <= 2'd0;
                in_ready  <= 1'b0;
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            state     <= ONE;
                            out_valid <= 1'b1;
                            out_data  <= in_data;
                            out_halt  <= in_halt;
                            occupancy <= 2'd1;
                            in_ready  <= 1'b1;
                        end
                    end
                    ONE: begin
                        if (accept && pop) begin
                            out_data <= in_data;
                            out_halt <= in_halt;
                        end else if (accept) begin
                            state     <= FULL;
                            skid_data <= in_data;
                            skid_halt <= in_halt;
                            occupancy <= 2'd2;
                            in_ready  <= 1'b0;
                        end else if (pop) begin
                            state     <= EMPTY;
                            out_valid <= 1'b0;
                            occupancy <= 2'd0;
                            in_ready  <= 1'b1;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            state     <= ONE;
                            out_data  <= skid_data;
                            out_halt  <= skid_halt;
                            occupancy <= 2'd1;
                            in_ready  <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        occupancy <= 2'd0;
                        in_ready  <= !halted;
                    end
                endcase
            end
        end
    end

endmodule
